// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes minuend - subtrahend - borrow one bit per clock, LSB first,
// through a single full-subtractor cell, with a start/busy/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    input  logic             i_borrow,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             brw;
    logic [CNT_W-1:0] cnt;

    logic             d_bit;
    logic             b_out;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell on the current LSBs; difference bit enters the result from the MSB side
    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ brw;
        b_out    = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
        res_next = {d_bit, res_sh[WIDTH-1:1]};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = SHIFT;
            SHIFT:   if (cnt == LAST_BIT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            brw      <= 1'b0;
            cnt      <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_diff   <= '0;
            o_borrow <= 1'b0;
        end else begin
            o_busy <= (state_next == SHIFT);
            o_done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (i_start) begin
                        a_sh   <= i_minuend;
                        b_sh   <= i_subtrahend;
                        brw    <= i_borrow;
                        cnt    <= '0;
                        res_sh <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    res_sh <= res_next;
                    brw    <= b_out;
                    cnt    <= cnt + CNT_W'(1);
                    // Publish the finished word on the edge that processes the MSB
                    if (cnt == LAST_BIT) begin
                        o_diff   <= res_next;
                        o_borrow <= b_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    logic       i_clk;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_minuend;
    logic [7:0] i_subtrahend;
    logic       i_borrow;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_diff;
    logic       o_borrow;

    int vectors;
    int miscompares;

    serial_subtractor #(.WIDTH(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_minuend   (i_minuend),
        .i_subtrahend(i_subtrahend),
        .i_borrow    (i_borrow),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_diff      (o_diff),
        .o_borrow    (o_borrow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Stimulus only: start one op and watch negedges until o_done or budget expiry
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output logic [7:0] d, output logic bo,
                          output int done_at, output int busy_cnt);
        @(negedge i_clk);
        i_minuend    = a;
        i_subtrahend = b;
        i_borrow     = bin;
        i_start      = 1'b1;
        @(posedge i_clk);
        #1;
        i_start      = 1'b0;
        i_minuend    = 8'hC3;
        i_subtrahend = 8'h3C;
        i_borrow     = ~bin;
        done_at  = 0;
        busy_cnt = 0;
        d  = 8'h00;
        bo = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge i_clk);
            if (o_busy) busy_cnt++;
            if (o_done) begin
                done_at = k;
                d  = o_diff;
                bo = o_borrow;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b0;
        i_minuend = 8'h00; i_subtrahend = 8'h00; i_borrow = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        vectors++;
        if ({o_busy, o_done, o_diff, o_borrow} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h borrow=%b, want all 0",
                     o_busy, o_done, o_diff, o_borrow);
        end
        // start held together with reset must be lost
        i_start = 1'b1; i_minuend = 8'h44; i_subtrahend = 8'h11;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0; i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_beats_start: busy=%b, want 0", o_busy);
        end
    endtask

    task automatic check_op(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic bin, input logic [7:0] exp_d, input logic exp_bo);
        logic [7:0] d; logic bo; int done_at; int busy_cnt;
        run_op(a, b, bin, d, bo, done_at, busy_cnt);
        vectors++;
        if (done_at !== 9) begin
            miscompares++;
            $display("FAIL %s latency: done at %0d, want 9", name, done_at);
        end
        vectors++;
        if (d !== exp_d) begin
            miscompares++;
            $display("FAIL %s diff: got %h, want %h", name, d, exp_d);
        end
        vectors++;
        if (bo !== exp_bo) begin
            miscompares++;
            $display("FAIL %s borrow: got %b, want %b", name, bo, exp_bo);
        end
        vectors++;
        if (busy_cnt !== 8) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d, want 8", name, busy_cnt);
        end
    endtask

    task automatic test_basic();
        check_op("basic_5a_23", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
        @(negedge i_clk);
        vectors++;
        if (o_done !== 1'b0 || o_diff !== 8'h37) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b diff=%h, want done=0 diff=37", o_done, o_diff);
        end
    endtask

    task automatic test_borrow();
        check_op("under_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        check_op("bin_10_10",   8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
        check_op("ff_00_b1",    8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0);
        check_op("80_7f",       8'h80, 8'h7F, 1'b0, 8'h01, 1'b0);
    endtask

    task automatic test_start_ignored();
        int dones;
        @(negedge i_clk);
        i_minuend = 8'h5A; i_subtrahend = 8'h23; i_borrow = 1'b0; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        dones = 0;
        for (int k = 2; k <= 25; k++) begin
            if (k == 4) begin
                i_minuend = 8'h01; i_subtrahend = 8'h01; i_start = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            if (o_done) dones++;
            @(negedge i_clk);
        end
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL ignore_start_dones: got %0d, want 1", dones);
        end
        vectors++;
        if (o_diff !== 8'h37) begin
            miscompares++;
            $display("FAIL ignore_start_diff: got %h, want 37", o_diff);
        end
    endtask

    task automatic test_mid_reset();
        int dones;
        @(negedge i_clk);
        i_minuend = 8'h5A; i_subtrahend = 8'h23; i_borrow = 1'b0; i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        vectors++;
        if ({o_busy, o_done, o_diff, o_borrow} !== 11'd0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b diff=%h borrow=%b, want all 0",
                     o_busy, o_done, o_diff, o_borrow);
        end
        i_rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge i_clk);
            if (o_done || o_busy) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL mid_reset_quiet: %0d busy/done cycles, want 0", dones);
        end
        check_op("after_reset_09_04", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a_q; logic [7:0] b_q; logic bin_q;
        logic [8:0] ref_v;
        int since;
        int ops;
        bit timed_out;
        a_q = 8'h00; b_q = 8'h00; bin_q = 1'b0;
        @(negedge i_clk);
        i_minuend = a_q; i_subtrahend = b_q; i_borrow = bin_q; i_start = 1'b1;
        ops = 0;
        since = 0;
        timed_out = 0;
        while (ops < 1100 && !timed_out) begin
            @(negedge i_clk);
            since++;
            if (since > 15) begin
                timed_out = 1;
                vectors++;
                miscompares++;
                $display("FAIL b2b_timeout: no done within 15 cycles at op %0d", ops);
            end else if (o_done) begin
                ref_v = {1'b0, a_q} - {1'b0, b_q} - 9'(bin_q);
                vectors++;
                if ({o_borrow, o_diff} !== ref_v) begin
                    miscompares++;
                    $display("FAIL b2b_op%0d: %h-%h-%b got borrow=%b diff=%h, want borrow=%b diff=%h",
                             ops, a_q, b_q, bin_q, o_borrow, o_diff, ref_v[8], ref_v[7:0]);
                end
                if (ops > 0) begin
                    vectors++;
                    if (since !== 10) begin
                        miscompares++;
                        $display("FAIL b2b_interval op%0d: got %0d cycles, want 10", ops, since);
                    end
                end
                ops++;
                since = 0;
                case (ops)
                    1: begin a_q = 8'h00; b_q = 8'hFF; bin_q = 1'b0; end
                    2: begin a_q = 8'hFF; b_q = 8'hFF; bin_q = 1'b1; end
                    3: begin a_q = 8'h00; b_q = 8'h00; bin_q = 1'b1; end
                    4: begin a_q = 8'hFF; b_q = 8'h00; bin_q = 1'b0; end
                    5: begin a_q = 8'h00; b_q = 8'hFF; bin_q = 1'b1; end
                    default: begin
                        case ($urandom_range(0, 5))
                            0:       a_q = 8'h00;
                            1:       a_q = 8'hFF;
                            default: a_q = 8'($urandom);
                        endcase
                        case ($urandom_range(0, 5))
                            0:       b_q = 8'h00;
                            1:       b_q = 8'hFF;
                            default: b_q = 8'($urandom);
                        endcase
                        bin_q = 1'($urandom);
                    end
                endcase
                i_minuend = a_q; i_subtrahend = b_q; i_borrow = bin_q;
            end
        end
        i_start = 1'b0;
        repeat (12) @(negedge i_clk);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
